// File: rtl/inf_frame_scheduler.sv
// Write-side sequencer for the ping-pong info buffer ahead of the BMST-NBLDPC encoder.
// Optional build macro INF_SCHED_PRBS_EN replaces the source stream with an internal PRBS-15.
module inf_frame_scheduler #(
  parameter int SYM_BITS    = 6,
  parameter int FRAME_SYMS  = 49,
  parameter int DATA_FRAMES = 20,
  parameter int TERM_FRAMES = 2
) (
  input  logic       wclk,
  input  logic       rst,
  input  logic       start,
  input  logic       src_bit,
  input  logic       src_valid,
  output logic       src_ready,
  input  logic       buf_ready,
  input  logic       buf_full,
  output logic       buf_valid_in,
  output logic       buf_inf_bit,
  output logic [7:0] frame_idx,
  output logic       term_phase,
  output logic       busy,
  output logic       done
);

  localparam int FRAME_BITS = SYM_BITS * FRAME_SYMS;
  localparam int CNT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(FRAME_BITS - 1);
  localparam logic [7:0]       L_IDX      = 8'(DATA_FRAMES);
  localparam logic [7:0]       LAST_FRAME = 8'(DATA_FRAMES + TERM_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_TERM,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]       frame_idx_q, frame_idx_d;
  logic             term_phase_q, term_phase_d;
  logic             valid_q, valid_d;
  logic             bit_q, bit_d;

  logic go;
  logic data_fire;
  logic term_fire;
  logic data_bit;

  assign go        = buf_ready & ~buf_full;
  assign term_fire = (state_q == S_TERM) & go;

`ifdef INF_SCHED_PRBS_EN
  localparam logic [14:0] PRBS_SEED = 15'h7FFF;
  logic [14:0] prbs_q, prbs_d;
  logic        unused_src;

  assign unused_src = src_bit ^ src_valid;
  assign src_ready  = 1'b0;
  assign data_fire  = (state_q == S_DATA) & go;
  assign data_bit   = prbs_q[14];

  always_comb begin
    prbs_d = prbs_q;
    if (state_q == S_IDLE && start) begin
      prbs_d = PRBS_SEED;
    end else if (data_fire) begin
      prbs_d = {prbs_q[13:0], prbs_q[14] ^ prbs_q[13]};
    end
  end

  always_ff @(posedge wclk or negedge rst) begin
    if (!rst) prbs_q <= PRBS_SEED;
    else      prbs_q <= prbs_d;
  end
`else
  assign src_ready = (state_q == S_DATA) & go;
  assign data_fire = src_ready & src_valid;
  assign data_bit  = src_bit;
`endif

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    frame_idx_d  = frame_idx_q;
    term_phase_d = term_phase_q;
    valid_d      = 1'b0;
    bit_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_WAIT;
          bit_cnt_d    = '0;
          frame_idx_d  = 8'd0;
          term_phase_d = (DATA_FRAMES == 0);
        end
      end

      S_WAIT: begin
        if (go) state_d = (frame_idx_q < L_IDX) ? S_DATA : S_TERM;
      end

      S_DATA, S_TERM: begin
        if (data_fire || term_fire) begin
          valid_d = 1'b1;
          bit_d   = (state_q == S_DATA) ? data_bit : 1'b0;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (frame_idx_q == LAST_FRAME) begin
              state_d = S_DONE;
            end else begin
              state_d      = S_GAP;
              frame_idx_d  = frame_idx_q + 8'd1;
              term_phase_d = ((frame_idx_q + 8'd1) >= L_IDX);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      // The just-filled bank may still show ready; wait for the drop first.
      S_GAP: begin
        if (!buf_ready) state_d = S_WAIT;
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      frame_idx_q  <= 8'd0;
      term_phase_q <= 1'b0;
      valid_q      <= 1'b0;
      bit_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_idx_q  <= frame_idx_d;
      term_phase_q <= term_phase_d;
      valid_q      <= valid_d;
      bit_q        <= bit_d;
    end
  end

  assign buf_valid_in = valid_q;
  assign buf_inf_bit  = bit_q;
  assign frame_idx    = frame_idx_q;
  assign term_phase   = term_phase_q;
  assign busy         = (state_q == S_WAIT) || (state_q == S_DATA) ||
                        (state_q == S_TERM) || (state_q == S_GAP);
  assign done         = (state_q == S_DONE);

endmodule
